// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : control_unit
//  Purpose  : Multi-cycle accumulator CPU sequencer. Fetches two-byte
//             instructions (opcode, operand) over a req/ack memory port,
//             drives an external ALU and holds ACC, PC and the fz/fc flags.
//  Revision : 1.0  initial release
// ============================================================================
module control_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic [7:0] mem_addr_o,
  output logic [7:0] mem_wdata_o,
  input  logic [7:0] mem_rdata_i,
  input  logic       mem_ack_i,
  output logic [7:0] alu_x_o,
  output logic [7:0] alu_y_o,
  output logic [2:0] alu_op_o,
  input  logic [7:0] alu_r_i,
  input  logic [1:0] alu_flags_i,
  output logic [7:0] acc_o,
  output logic [7:0] pc_o,
  output logic [1:0] flags_o,
  output logic       halted_o,
  output logic       instr_done_o
);

  localparam logic [2:0] FETCH_OP  = 3'd0;
  localparam logic [2:0] FETCH_ARG = 3'd1;
  localparam logic [2:0] EXEC      = 3'd2;
  localparam logic [2:0] READ      = 3'd3;
  localparam logic [2:0] WRITE     = 3'd4;
  localparam logic [2:0] HALT      = 3'd5;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_LDA = 4'b0010;
  localparam logic [3:0] OP_STA = 4'b0011;
  localparam logic [3:0] OP_JMP = 4'b0100;
  localparam logic [3:0] OP_JZ  = 4'b0101;
  localparam logic [3:0] OP_JC  = 4'b0110;
  localparam logic [3:0] OP_LDI = 4'b0111;
  localparam logic [3:0] OP_HLT = 4'b1111;

  logic [2:0] state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] acc_q, acc_d;
  // Only the opcode nibble of the instruction byte is ever used, so only it is kept.
  logic [7:4] ir_q, ir_d;
  logic [7:0] arg_q, arg_d;
  logic       fz_q, fz_d;
  logic       fc_q, fc_d;

  logic       req;
  logic       xfer;
  logic       mem_op;

  // Memory port request and address decode; reset forces the request low at once.
  always_comb begin
    req         = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 8'h00;
    unique case (state_q)
      FETCH_OP, FETCH_ARG: begin
        req        = rst_ni;
        mem_addr_o = rst_ni ? pc_q : 8'h00;
      end
      READ: begin
        req        = rst_ni;
        mem_addr_o = rst_ni ? arg_q : 8'h00;
      end
      WRITE: begin
        req        = rst_ni;
        mem_we_o   = rst_ni;
        mem_addr_o = rst_ni ? arg_q : 8'h00;
      end
      default: ;
    endcase
  end

  assign mem_req_o   = req;
  assign xfer        = req & mem_ack_i;
  assign mem_wdata_o = acc_q;
  assign alu_x_o     = acc_q;
  assign alu_y_o     = (state_q == READ) ? mem_rdata_i : arg_q;
  assign alu_op_o    = ir_q[6:4];
  assign acc_o       = acc_q;
  assign pc_o        = pc_q;
  assign flags_o     = {fc_q, fz_q};
  assign halted_o    = (state_q == HALT);
  assign mem_op      = (ir_q == OP_ADD) || (ir_q == OP_SUB) ||
                       (ir_q == OP_LDA) || (ir_q == OP_STA);

  // Final cycle of an instruction: EXEC for non-memory ops (HLT included, as it
  // enters HALT on this edge), or the completing cycle of READ/WRITE.
  always_comb begin
    instr_done_o = 1'b0;
    if (rst_ni) begin
      if (state_q == EXEC)
        instr_done_o = !mem_op;
      else if ((state_q == READ) || (state_q == WRITE))
        instr_done_o = xfer;
    end
  end

  // Next-state and datapath update logic for the instruction sequencer.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    ir_d    = ir_q;
    arg_d   = arg_q;
    fz_d    = fz_q;
    fc_d    = fc_q;
    unique case (state_q)
      FETCH_OP: if (xfer) begin
        ir_d    = mem_rdata_i[7:4];
        pc_d    = pc_q + 8'd1;
        state_d = FETCH_ARG;
      end
      FETCH_ARG: if (xfer) begin
        arg_d   = mem_rdata_i;
        pc_d    = pc_q + 8'd1;
        state_d = EXEC;
      end
      EXEC: begin
        state_d = FETCH_OP;
        case (ir_q)
          OP_ADD, OP_SUB, OP_LDA: state_d = READ;
          OP_STA: state_d = WRITE;
          OP_JMP: pc_d = arg_q;
          OP_JZ:  if (fz_q) pc_d = arg_q;
          OP_JC:  if (fc_q) pc_d = arg_q;
          OP_LDI: begin
            acc_d = alu_r_i;
            fz_d  = alu_flags_i[0];
          end
          OP_HLT: state_d = HALT;
          default: ;
        endcase
      end
      READ: if (xfer) begin
        acc_d   = alu_r_i;
        fz_d    = alu_flags_i[0];
        // Carry is architecturally meaningful only for arithmetic.
        if ((ir_q == OP_ADD) || (ir_q == OP_SUB))
          fc_d = alu_flags_i[1];
        state_d = FETCH_OP;
      end
      WRITE: if (xfer) state_d = FETCH_OP;
      HALT: state_d = HALT;
      default: state_d = FETCH_OP;
    endcase
  end

  // Architectural state registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FETCH_OP;
      pc_q    <= RESET_PC;
      acc_q   <= 8'h00;
      ir_q    <= 4'h0;
      arg_q   <= 8'h00;
      fz_q    <= 1'b0;
      fc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ir_q    <= ir_d;
      arg_q   <= arg_d;
      fz_q    <= fz_d;
      fc_q    <= fc_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_control_unit
//  Purpose  : Directed bench for control_unit with memory and ALU models.
//  Revision : 1.0  initial release
// ============================================================================
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       mem_req_o, mem_we_o;
  logic [7:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic       mem_ack_i;
  logic [7:0] alu_x_o, alu_y_o, alu_r_i;
  logic [2:0] alu_op_o;
  logic [1:0] alu_flags_i;
  logic [7:0] acc_o, pc_o;
  logic [1:0] flags_o;
  logic       halted_o, instr_done_o;

  control_unit #(.RESET_PC(8'h00)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .alu_x_o(alu_x_o), .alu_y_o(alu_y_o), .alu_op_o(alu_op_o),
    .alu_r_i(alu_r_i), .alu_flags_i(alu_flags_i),
    .acc_o(acc_o), .pc_o(pc_o), .flags_o(flags_o),
    .halted_o(halted_o), .instr_done_o(instr_done_o)
  );

  always #5 clk = ~clk;

  // Memory model: configurable wait states, optional ack withholding on 0x10.
  logic [7:0] mem [256];
  int         wait_n = 0;
  int         wcnt;
  int         wr_cnt = 0;
  bit         hold_read = 1'b0;

  assign mem_rdata_i = mem[mem_addr_o];
  assign mem_ack_i   = mem_req_o && (wcnt >= wait_n) && !(hold_read && mem_addr_o == 8'h10);

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) wcnt <= 0;
    else if (mem_req_o && mem_ack_i) wcnt <= 0;
    else if (mem_req_o) wcnt <= wcnt + 1;
  end

  always @(posedge clk) begin
    if (rst_ni && mem_req_o && mem_ack_i && mem_we_o) begin
      mem[mem_addr_o] <= mem_wdata_o;
      wr_cnt          <= wr_cnt + 1;
    end
  end

  // ALU model: add, subtract (carry = borrow), pass-through of y.
  logic [8:0] alu_full;
  always_comb begin
    alu_full = 9'h000;
    case (alu_op_o)
      3'd0:    alu_full = {1'b0, alu_x_o} + {1'b0, alu_y_o};
      3'd1:    alu_full = {1'b0, alu_x_o} - {1'b0, alu_y_o};
      default: alu_full = {1'b0, alu_y_o};
    endcase
  end
  assign alu_r_i     = alu_full[7:0];
  assign alu_flags_i = {alu_full[8], alu_full[7:0] == 8'h00};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    int         lat;
    logic [7:0] acc;
    logic [7:0] pc;
    logic       fz;
    logic       fc;
  } vec_t;

  vec_t vecs [14];

  // Called just after a rising edge at an instruction boundary.
  task automatic run_vec(input vec_t v);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_done_o && n < 40);
    chk({v.name, " latency"}, n, v.lat);
    @(posedge clk); #1;
    chk({v.name, " acc"}, acc_o, v.acc);
    chk({v.name, " pc"}, pc_o, v.pc);
    chk({v.name, " fz"}, flags_o[0], v.fz);
    chk({v.name, " fc"}, flags_o[1], v.fc);
  endtask

  initial begin
    int  n;
    int  hold;
    int  wr0;
    bit  stable;
    bit  done_seen;
    int  req_seen;
    int  done_cnt;

    vecs[0]  = '{"LDI 05",    3, 8'h05, 8'h02, 1'b0, 1'b0};
    vecs[1]  = '{"ADD [10]",  4, 8'h01, 8'h04, 1'b0, 1'b1};
    vecs[2]  = '{"LDI 05 b",  3, 8'h05, 8'h06, 1'b0, 1'b1};
    vecs[3]  = '{"SUB [11]",  4, 8'h00, 8'h08, 1'b1, 1'b0};
    vecs[4]  = '{"JZ 20",     3, 8'h00, 8'h20, 1'b1, 1'b0};
    vecs[5]  = '{"NOP",       3, 8'h00, 8'h22, 1'b1, 1'b0};
    vecs[6]  = '{"JC 40",     3, 8'h00, 8'h24, 1'b1, 1'b0};
    vecs[7]  = '{"LDI FF",    3, 8'hFF, 8'h26, 1'b0, 1'b0};
    vecs[8]  = '{"ADD [13]",  4, 8'h01, 8'h28, 1'b0, 1'b1};
    vecs[9]  = '{"LDA [12]",  4, 8'h00, 8'h2A, 1'b1, 1'b1};
    vecs[10] = '{"LDI A5",    3, 8'hA5, 8'h2C, 1'b0, 1'b1};
    vecs[11] = '{"JMP FF",    3, 8'hA5, 8'hFF, 1'b0, 1'b1};
    vecs[12] = '{"JMP wrap",  3, 8'hA5, 8'h70, 1'b0, 1'b1};
    vecs[13] = '{"HLT",       3, 8'hA5, 8'h72, 1'b0, 1'b1};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h70; mem[8'h01] = 8'h05;
    mem[8'h02] = 8'h00; mem[8'h03] = 8'h10;
    mem[8'h04] = 8'h70; mem[8'h05] = 8'h05;
    mem[8'h06] = 8'h10; mem[8'h07] = 8'h11;
    mem[8'h08] = 8'h50; mem[8'h09] = 8'h20;
    mem[8'h10] = 8'hFC; mem[8'h11] = 8'h05;
    mem[8'h12] = 8'h00; mem[8'h13] = 8'h02;
    mem[8'h20] = 8'h80; mem[8'h21] = 8'h00;
    mem[8'h22] = 8'h60; mem[8'h23] = 8'h40;
    mem[8'h24] = 8'h70; mem[8'h25] = 8'hFF;
    mem[8'h26] = 8'h00; mem[8'h27] = 8'h13;
    mem[8'h28] = 8'h20; mem[8'h29] = 8'h12;
    mem[8'h2A] = 8'h70; mem[8'h2B] = 8'hA5;
    mem[8'h2C] = 8'h30; mem[8'h2D] = 8'h30;
    mem[8'h2E] = 8'h40; mem[8'h2F] = 8'hFF;
    mem[8'hFF] = 8'h40;
    mem[8'h70] = 8'hF0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst req", mem_req_o, 1'b0);
    chk("rst we", mem_we_o, 1'b0);
    chk("rst addr", mem_addr_o, 8'h00);
    chk("rst pc", pc_o, 8'h00);
    chk("rst acc", acc_o, 8'h00);
    chk("rst flags", flags_o, 2'b00);
    chk("rst halted", halted_o, 1'b0);
    chk("rst done", instr_done_o, 1'b0);

    @(posedge clk); #1;
    rst_ni = 1'b1;
    #1;
    chk("first fetch req", mem_req_o, 1'b1);
    chk("first fetch addr", mem_addr_o, 8'h00);

    // Zero-wait instruction sequence, rows up to LDI A5.
    for (int i = 0; i <= 10; i++) run_vec(vecs[i]);

    // STA 30 with three wait states on every transfer.
    wr0    = wr_cnt;
    wait_n = 3;
    n      = 0;
    while (!(mem_req_o && mem_we_o) && n < 60) begin
      @(negedge clk);
      n++;
    end
    hold      = 0;
    stable    = 1'b1;
    done_seen = 1'b0;
    while (mem_req_o && mem_we_o && hold < 20) begin
      hold++;
      if (mem_addr_o != 8'h30 || mem_wdata_o != 8'hA5) stable = 1'b0;
      if (mem_ack_i) begin
        done_seen = instr_done_o;
        break;
      end
      @(negedge clk);
    end
    chk("STA hold cycles", hold, 4);
    chk("STA addr/wdata stable", stable, 1'b1);
    chk("STA done pulse", done_seen, 1'b1);
    @(posedge clk); #1;
    chk("STA write count", wr_cnt - wr0, 1);
    chk("STA M[30]", mem[8'h30], 8'hA5);
    chk("STA pc", pc_o, 8'h2E);
    chk("STA fc kept", flags_o[1], 1'b1);
    wait_n = 0;

    // Jump to FF; next instruction straddles the PC wrap.
    run_vec(vecs[11]);
    @(negedge clk);
    chk("wrap op addr", mem_addr_o, 8'hFF);
    @(negedge clk);
    chk("wrap arg req", mem_req_o, 1'b1);
    chk("wrap arg addr", mem_addr_o, 8'h00);
    @(negedge clk);
    chk("wrap pc after fetch", pc_o, 8'h01);
    chk("wrap exec done", instr_done_o, 1'b1);
    @(posedge clk); #1;
    chk("wrap jump pc", pc_o, vecs[12].pc);

    // HLT then idle: no more requests, no more done pulses.
    run_vec(vecs[13]);
    chk("halted", halted_o, 1'b1);
    req_seen = 0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_req_o) req_seen++;
      if (instr_done_o) done_cnt++;
    end
    chk("halt no req", req_seen, 0);
    chk("halt no done", done_cnt, 0);
    chk("halt addr", mem_addr_o, 8'h00);
    chk("halt stays", halted_o, 1'b1);

    // Reset out of HALT, then reset again in the middle of a stalled READ.
    @(posedge clk); #1;
    rst_ni    = 1'b0;
    hold_read = 1'b1;
    #1;
    chk("reset from halt halted", halted_o, 1'b0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    run_vec(vecs[0]);
    n = 0;
    while (!(mem_req_o && mem_addr_o == 8'h10) && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    @(negedge clk);
    chk("read stalled req", mem_req_o, 1'b1);
    chk("read stalled addr", mem_addr_o, 8'h10);
    rst_ni = 1'b0;
    #1;
    chk("mid-read rst req", mem_req_o, 1'b0);
    chk("mid-read rst addr", mem_addr_o, 8'h00);
    chk("mid-read rst pc", pc_o, 8'h00);
    chk("mid-read rst acc", acc_o, 8'h00);
    chk("mid-read rst flags", flags_o, 2'b00);
    chk("mid-read rst halted", halted_o, 1'b0);
    chk("mid-read rst done", instr_done_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have parameter RESET_PC, default 8'h00, which is the PC value loaded on reset.
REQ-003 clk_i  in  1  system clock; all state updates on the rising edge.
REQ-004 rst_ni  in  1  asynchronous active-low reset.
REQ-005 mem_req_o  out  1  memory access request.
REQ-006 mem_we_o  out  1  write enable, valid while mem_req_o=1.
REQ-007 mem_addr_o  out  8  access address; 8'h00 while mem_req_o=0.
REQ-008 mem_wdata_o  out  8  write data, equal to ACC.
REQ-009 mem_rdata_i  in  8  read data, sampled only in the cycle where mem_req_o and mem_ack_i are both 1.
REQ-010 mem_ack_i  in  1  access completion; ignored while mem_req_o=0.
REQ-011 alu_x_o  out  8  ALU x operand, always equal to ACC.
REQ-012 alu_y_o  out  8  ALU y operand: mem_rdata_i in READ, ARG otherwise.
REQ-013 alu_op_o  out  3  ALU operation, equal to IR[6:4].
REQ-014 alu_r_i  in  8  ALU result.
REQ-015 alu_flags_i  in  2  ALU flags: [0]=zero, [1]=carry.
REQ-016 acc_o, pc_o  out  8 each  architectural ACC and PC.
REQ-017 flags_o  out  2  latched flags: [0]=fz, [1]=fc.
REQ-018 halted_o  out  1  high while in state HALT.
REQ-019 instr_done_o  out  1  one-cycle pulse in the final cycle of every instruction.

Function
REQ-020 Every instruction SHALL be two bytes: an opcode byte (IR[7:4]=opcode, IR[3:0] ignored) followed by an operand byte (ARG).
REQ-021 The opcodes SHALL be:
- 0000 ADD: ACC=ACC+M[ARG]
- 0001 SUB: ACC=ACC-M[ARG]
- 0010 LDA: ACC=M[ARG]
- 0011 STA: M[ARG]=ACC
- 0100 JMP ARG
- 0101 JZ: jump if fz
- 0110 JC: jump if fc
- 0111 LDI: ACC=ARG
- 1111 HLT
- all other opcodes: NOP
REQ-022 The FSM states SHALL be FETCH_OP, FETCH_ARG, EXEC, READ, WRITE and HALT.
REQ-023 A transfer SHALL complete on each rising edge where mem_req_o=1 and mem_ack_i=1.
- Zero-wait (same-cycle) ack is legal.
- mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o SHALL stay stable until completion.
REQ-024 FETCH_OP SHALL drive req=1, we=0, addr=PC; on completion: IR<=rdata, PC<=PC+1, go to FETCH_ARG.
REQ-025 FETCH_ARG SHALL drive req=1, we=0, addr=PC; on completion: ARG<=rdata, PC<=PC+1, go to EXEC.
REQ-026 EXEC SHALL drive req=0 and act on the opcode:
- ADD/SUB/LDA: go to READ.
- STA: go to WRITE.
- JMP: PC<=ARG.
- JZ/JC: PC<=ARG only if the flag is set.
- LDI: ACC<=alu_r_i, fz<=alu_flags_i[0].
- HLT: go to HALT.
- All opcodes other than ADD/SUB/LDA/STA/HLT: go to FETCH_OP and pulse instr_done_o.
REQ-027 READ SHALL drive req=1, we=0, addr=ARG; on completion: ACC<=alu_r_i, fz<=alu_flags_i[0]; on ADD/SUB only, fc<=alu_flags_i[1]; pulse instr_done_o; go to FETCH_OP.
REQ-028 WRITE SHALL drive req=1, we=1, addr=ARG, wdata=ACC; on completion: pulse instr_done_o, go to FETCH_OP.
REQ-029 fc SHALL be unchanged by LDA, LDI, STA, jumps and NOP.
REQ-030 HALT SHALL drive req=0 and halted_o=1, pulse instr_done_o once on entry, and remain in HALT until reset.
REQ-031 PC SHALL wrap 8'hFF->8'h00, including between the opcode byte and the operand byte.
REQ-032 With zero-wait memory, latency SHALL be 3 cycles for JMP/JZ/JC/LDI/NOP/HLT and 4 cycles for ADD/SUB/LDA/STA; each wait cycle adds one cycle.
REQ-033 mem_req_o MAY stay high across back-to-back transfers (FETCH_OP->FETCH_ARG); each completion counts as exactly one transfer.

Reset
REQ-034 While rst_ni=0, the block SHALL hold the following values, asynchronously and including mid-transfer:
- state=FETCH_OP, PC=RESET_PC, ACC=0, IR=0, ARG=0, flags=0
- mem_req_o=0, mem_we_o=0, halted_o=0, instr_done_o=0
REQ-035 The first fetch SHALL begin in the first rising edge after rst_ni deasserts.

Verification
REQ-036 The bench SHALL cover the following directed scenarios:
- Zero-wait memory, program LDI 05; ADD [10], M[10]=FC -> ACC=01, fc=1, fz=0; instr_done_o pulses at cycles 3 and 7.
- ACC=05, SUB [11], M[11]=05 -> ACC=00, fz=1, fc=0; then JZ 20 -> PC=20; then JC 40 -> PC=24 (not taken).
- STA 30 with ACC=A5, ack delayed 3 cycles -> req/we/addr=30/wdata=A5 held 4 cycles; exactly one write; M[30]=A5.
- LDA [12], M[12]=00, after fc=1 -> ACC=00, fz=1, fc stays 1.
- Opcode byte at FF, operand byte at 00 -> operand fetch addr=00, PC=01 after fetch.
- HLT (F0) -> halted_o=1, no further mem_req_o; later, rst_ni=0 asserted mid-READ with ack withheld -> req drops the same cycle, PC=RESET_PC, halted_o=0.
